i2s_transmitter: RTL

Serialises stereo 16-bit PCM from the audio mixer onto an I2S link (Philips format, 16 bits per slot, 32 bit clocks per frame). Generates `bclk` and `lrclk` from the system clock. `lrclk` is also fed back to the mixer as its render timebase. The block sits directly downstream of the mixer, holds one pending sample per channel, and flags underruns when the mixer fails to refresh a channel before that channel's slot starts.

---
 rtl/audio_pkg.sv | 24 ++
 rtl/i2s_clock_gen.sv | 53 +++++
 rtl/i2s_transmitter.sv | 97 +++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared audio definitions used by the mixer and the I2S transmitter.
package audio_pkg;

    localparam int SAMPLE_WIDTH = 16;
    localparam int SLOT_BITS = 16;
    localparam int FRAME_BITS = 32;
    localparam int COUNT_WIDTH = 16;

    // Falling-edge indices at which each slot's shift register is loaded.
    localparam int LOAD_LEFT_BIT = 1;
    localparam int LOAD_RIGHT_BIT = SLOT_BITS + 1;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } channelT;

    function automatic logic [COUNT_WIDTH-1:0] satInc(
        input logic [COUNT_WIDTH-1:0] v
    );
        return (v == {COUNT_WIDTH{1'b1}}) ? v : v + COUNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/i2s_clock_gen.sv
// I2S bit/word clock generation and slot load strobes.
module i2s_clock_gen
    import audio_pkg::*;
#(
    parameter int BCLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic bclk,
    output logic lrclk,
    output logic fall,
    output logic loadLeft,
    output logic loadRight
);

    localparam int CW = $clog2(BCLK_DIV);
    localparam int FW = $clog2(FRAME_BITS);

    logic [CW-1:0] divCnt;
    logic [FW-1:0] f;
    logic [FW-1:0] fNext;
    logic          divLast;

    assign divLast = (divCnt == CW'(BCLK_DIV - 1));
    assign fNext = f + FW'(1);

    // Strobes describe what the current clk edge does, so the top can
    // update its registers on the same edge that bclk falls.
    assign fall = bclk && divLast;
    assign loadLeft = fall && (fNext == FW'(LOAD_LEFT_BIT));
    assign loadRight = fall && (fNext == FW'(LOAD_RIGHT_BIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            divCnt <= '0;
            bclk <= 1'b0;
            f <= '1;
            lrclk <= 1'b1;
        end else begin
            if (divLast) begin
                divCnt <= '0;
                bclk <= !bclk;
            end else begin
                divCnt <= divCnt + CW'(1);
            end
            if (fall) begin
                f <= fNext;
                lrclk <= fNext[FW-1];
            end
        end
    end

endmodule

// File: rtl/i2s_transmitter.sv
// Stereo 16-bit I2S transmitter with per-channel hold registers and
// underrun detection.
module i2s_transmitter
    import audio_pkg::*;
#(
    parameter int BCLK_DIV = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    input  logic                    sample_valid,
    input  logic                    sample_is_left,
    output logic                    bclk,
    output logic                    lrclk,
    output logic                    sdata,
    output logic                    underrun,
    output logic [COUNT_WIDTH-1:0]  underrun_count
);

    logic fall;
    logic loadLeft;
    logic loadRight;

    logic [SAMPLE_WIDTH-1:0] leftHold;
    logic [SAMPLE_WIDTH-1:0] rightHold;
    logic [SAMPLE_WIDTH-1:0] shiftReg;
    logic                    leftFresh;
    logic                    rightFresh;
    logic [COUNT_WIDTH-1:0]  underrunCnt;

    channelT wrCh;
    logic    wrLeft;
    logic    wrRight;
    logic    staleLoad;

    i2s_clock_gen #(
        .BCLK_DIV(BCLK_DIV)
    ) clockGen (
        .clk(clk),
        .rst(rst),
        .bclk(bclk),
        .lrclk(lrclk),
        .fall(fall),
        .loadLeft(loadLeft),
        .loadRight(loadRight)
    );

    assign wrCh = sample_is_left ? CH_LEFT : CH_RIGHT;
    assign wrLeft = sample_valid && (wrCh == CH_LEFT);
    assign wrRight = sample_valid && (wrCh == CH_RIGHT);

    assign staleLoad = (loadLeft && !leftFresh) ||
                       (loadRight && !rightFresh);

    // A write landing on its own channel's load edge wins over the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            leftHold <= '0;
            rightHold <= '0;
            leftFresh <= 1'b0;
            rightFresh <= 1'b0;
        end else begin
            if (loadLeft) leftFresh <= 1'b0;
            if (loadRight) rightFresh <= 1'b0;
            if (wrLeft) begin
                leftHold <= sample;
                leftFresh <= 1'b1;
            end
            if (wrRight) begin
                rightHold <= sample;
                rightFresh <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shiftReg <= '0;
            underrun <= 1'b0;
            underrunCnt <= '0;
        end else begin
            if (loadLeft) begin
                shiftReg <= leftHold;
            end else if (loadRight) begin
                shiftReg <= rightHold;
            end else if (fall) begin
                shiftReg <= {shiftReg[SAMPLE_WIDTH-2:0], 1'b0};
            end
            underrun <= staleLoad;
            if (staleLoad) underrunCnt <= satInc(underrunCnt);
        end
    end

    assign sdata = shiftReg[SAMPLE_WIDTH-1];
    assign underrun_count = underrunCnt;

endmodule
